// File: rtl/irq_ctrl_pkg.sv
// Shared register map, bit positions and address decode for the interrupt controller.
package irq_ctrl_pkg;

  // Register byte offsets
  localparam int unsigned REG_CTRL      = 32'h00;
  localparam int unsigned REG_ENABLE    = 32'h04;
  localparam int unsigned REG_MODE      = 32'h08;
  localparam int unsigned REG_PENDING   = 32'h0C;
  localparam int unsigned REG_RAW       = 32'h10;
  localparam int unsigned REG_CLAIM     = 32'h14;
  localparam int unsigned REG_COMPLETE  = 32'h18;
  localparam int unsigned REG_SWTRIG    = 32'h1C;
  localparam int unsigned REG_INSERVICE = 32'h20;

  // Bit positions inside registers
  localparam int unsigned CTRL_EN_BIT     = 0;
  localparam int unsigned CLAIM_VALID_BIT = 31;

  // One-hot-free register selector produced by the address decoder
  typedef enum logic [3:0] {
    SEL_CTRL,
    SEL_ENABLE,
    SEL_MODE,
    SEL_PENDING,
    SEL_RAW,
    SEL_CLAIM,
    SEL_COMPLETE,
    SEL_SWTRIG,
    SEL_INSERVICE,
    SEL_NONE
  } reg_sel_e;

  // Map a zero-extended register address onto a selector; unmapped -> SEL_NONE
  function automatic reg_sel_e decode_addr(input logic [31:0] addr);
    reg_sel_e sel;
    case (addr)
      REG_CTRL:      sel = SEL_CTRL;
      REG_ENABLE:    sel = SEL_ENABLE;
      REG_MODE:      sel = SEL_MODE;
      REG_PENDING:   sel = SEL_PENDING;
      REG_RAW:       sel = SEL_RAW;
      REG_CLAIM:     sel = SEL_CLAIM;
      REG_COMPLETE:  sel = SEL_COMPLETE;
      REG_SWTRIG:    sel = SEL_SWTRIG;
      REG_INSERVICE: sel = SEL_INSERVICE;
      default:       sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/irq_ctrl_prio_enc.sv
// Fixed-priority find-first-set: lowest set index wins, purely combinational.
module irq_prio_enc #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned ID_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec,
  output logic             any_c,
  output logic [ID_W-1:0]  id_c
);

  // Scan from the top down so the lowest set index is the last to overwrite id_c
  always_comb begin
    any_c = 1'b0;
    id_c  = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (vec[i]) begin
        any_c = 1'b1;
        id_c  = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: input synchronisers, edge/level pending capture, fixed-priority
// arbitration and a claim/complete handshake over a simple register bus.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter  int unsigned NUM_SRC     = 8,
  parameter  int unsigned SYNC_STAGES = 2,
  parameter  int unsigned ADDR_WIDTH  = 8,
  parameter  int unsigned DATA_WIDTH  = 32,
  localparam int unsigned ID_W        = $clog2(NUM_SRC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_SRC-1:0]    irq_src,
  output logic                  irq_out,
  output logic [ID_W-1:0]       irq_id,
  input  logic                  reg_wr,
  input  logic                  reg_rd,
  input  logic [ADDR_WIDTH-1:0] reg_addr,
  input  logic [DATA_WIDTH-1:0] reg_wdata,
  output logic [DATA_WIDTH-1:0] reg_rdata
);

  // State
  logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
  logic [NUM_SRC-1:0] hist_q;
  logic [NUM_SRC-1:0] pend_q;
  logic [NUM_SRC-1:0] ins_q;
  logic [NUM_SRC-1:0] enable_q;
  logic [NUM_SRC-1:0] mode_q;
  logic               ctrl_en_q;

  // Combinational helpers
  reg_sel_e           sel_c;
  logic [NUM_SRC-1:0] synced_c;
  logic [NUM_SRC-1:0] rise_c;
  logic [NUM_SRC-1:0] pending_c;
  logic [NUM_SRC-1:0] eligible_c;
  logic               elig_any_c;
  logic [ID_W-1:0]    elig_id_c;
  logic               claim_valid_c;
  logic               claim_fire_c;
  logic [NUM_SRC-1:0] claim_mask_c;
  logic [ID_W-1:0]    cmp_id_c;
  logic [NUM_SRC-1:0] cmp_mask_c;
  logic [NUM_SRC-1:0] wdata_src_c;
  logic [NUM_SRC-1:0] pend_set_c;
  logic [NUM_SRC-1:0] pend_clr_c;
  logic               wr_ctrl_c;
  logic               wr_enable_c;
  logic               wr_mode_c;
  logic               wr_pending_c;
  logic               wr_complete_c;
  logic               wr_swtrig_c;
  logic               unused_wdata;

  // Only the low bits of write data carry per-source meaning
  assign unused_wdata = ^reg_wdata;

  // Address decode and write strobes
  assign sel_c         = decode_addr(32'(reg_addr));
  assign wr_ctrl_c     = reg_wr & (sel_c == SEL_CTRL);
  assign wr_enable_c   = reg_wr & (sel_c == SEL_ENABLE);
  assign wr_mode_c     = reg_wr & (sel_c == SEL_MODE);
  assign wr_pending_c  = reg_wr & (sel_c == SEL_PENDING);
  assign wr_complete_c = reg_wr & (sel_c == SEL_COMPLETE);
  assign wr_swtrig_c   = reg_wr & (sel_c == SEL_SWTRIG);
  assign wdata_src_c   = reg_wdata[NUM_SRC-1:0];

  // Input synchroniser chain; the last stage is the synced view of the sources
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < int'(SYNC_STAGES); s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= irq_src;
      for (int s = 1; s < int'(SYNC_STAGES); s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign synced_c = sync_q[SYNC_STAGES-1];

  // Edge history runs regardless of MODE so switching to edge mode never fakes an edge
  assign rise_c     = synced_c & ~hist_q;
  assign pending_c  = pend_q | (~mode_q & synced_c);
  assign eligible_c = pending_c & enable_q & ~ins_q;

  irq_prio_enc #(
    .WIDTH (NUM_SRC)
  ) u_prio (
    .vec   (eligible_c),
    .any_c (elig_any_c),
    .id_c  (elig_id_c)
  );

  // Claim takes the current winner; it only fires on a qualified read with a valid winner
  assign claim_valid_c = elig_any_c & ctrl_en_q;
  assign claim_fire_c  = reg_rd & (sel_c == SEL_CLAIM) & claim_valid_c;
  assign claim_mask_c  = claim_fire_c ? (NUM_SRC'(1) << elig_id_c) : '0;

  // Complete clears one in-service bit; out-of-range ids do nothing
  assign cmp_id_c   = reg_wdata[ID_W-1:0];
  assign cmp_mask_c = (wr_complete_c && (32'(cmp_id_c) < NUM_SRC)) ?
                      (NUM_SRC'(1) << cmp_id_c) : '0;

  // Set sources always beat clear sources on the same bit
  assign pend_set_c = (rise_c & mode_q) | (wr_swtrig_c ? wdata_src_c : '0);
  assign pend_clr_c = (wr_pending_c ? wdata_src_c : '0) | claim_mask_c;

  // Configuration, pending and in-service state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_q    <= '0;
      pend_q    <= '0;
      ins_q     <= '0;
      enable_q  <= '0;
      mode_q    <= '0;
      ctrl_en_q <= 1'b0;
    end else begin
      hist_q <= synced_c;
      pend_q <= (pend_q & ~pend_clr_c) | pend_set_c;
      ins_q  <= (ins_q & ~cmp_mask_c) | claim_mask_c;
      if (wr_ctrl_c) begin
        ctrl_en_q <= reg_wdata[CTRL_EN_BIT];
      end
      if (wr_enable_c) begin
        enable_q <= wdata_src_c;
      end
      if (wr_mode_c) begin
        mode_q <= wdata_src_c;
      end
    end
  end

  // Registered CPU interrupt and winning ID
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_out <= 1'b0;
      irq_id  <= '0;
    end else begin
      irq_out <= ctrl_en_q & elig_any_c;
      irq_id  <= elig_any_c ? elig_id_c : '0;
    end
  end

  // Read mux; write-only and unmapped addresses return zero
  always_comb begin
    reg_rdata = '0;
    case (sel_c)
      SEL_CTRL:      reg_rdata[CTRL_EN_BIT] = ctrl_en_q;
      SEL_ENABLE:    reg_rdata = DATA_WIDTH'(enable_q);
      SEL_MODE:      reg_rdata = DATA_WIDTH'(mode_q);
      SEL_PENDING:   reg_rdata = DATA_WIDTH'(pending_c);
      SEL_RAW:       reg_rdata = DATA_WIDTH'(synced_c);
      SEL_INSERVICE: reg_rdata = DATA_WIDTH'(ins_q);
      SEL_CLAIM: begin
        if (claim_valid_c) begin
          reg_rdata[CLAIM_VALID_BIT] = 1'b1;
          reg_rdata[ID_W-1:0]        = elig_id_c;
        end
      end
      default: reg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus randomized traffic
// compared against a per-source behavioural model.
module tb_irq_ctrl;

  localparam int unsigned NUM_SRC     = 8;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned ADDR_WIDTH  = 8;
  localparam int unsigned DATA_WIDTH  = 32;

  localparam logic [7:0] A_CTRL      = 8'h00;
  localparam logic [7:0] A_ENABLE    = 8'h04;
  localparam logic [7:0] A_MODE      = 8'h08;
  localparam logic [7:0] A_PENDING   = 8'h0C;
  localparam logic [7:0] A_RAW       = 8'h10;
  localparam logic [7:0] A_CLAIM     = 8'h14;
  localparam logic [7:0] A_COMPLETE  = 8'h18;
  localparam logic [7:0] A_SWTRIG    = 8'h1C;
  localparam logic [7:0] A_INSERVICE = 8'h20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  irq_src = '0;
  logic        irq_out;
  logic [2:0]  irq_id;
  logic        reg_wr = 1'b0;
  logic        reg_rd = 1'b0;
  logic [7:0]  reg_addr = '0;
  logic [31:0] reg_wdata = '0;
  logic [31:0] reg_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  irq_ctrl #(
    .NUM_SRC     (NUM_SRC),
    .SYNC_STAGES (SYNC_STAGES),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_src   (irq_src),
    .irq_out   (irq_out),
    .irq_id    (irq_id),
    .reg_wr    (reg_wr),
    .reg_rd    (reg_rd),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata)
  );

  // ---------------- behavioural model ----------------
  bit         m_en;
  bit [7:0]   m_enable, m_mode, m_pend, m_ins, m_hist;
  bit         m_irq_out;
  bit [2:0]   m_irq_id;
  bit [7:0]   m_pipe[$];   // raw input samples; front is what the controller currently sees

  function automatic void m_clear();
    m_en = 0; m_enable = 0; m_mode = 0; m_pend = 0; m_ins = 0; m_hist = 0;
    m_irq_out = 0; m_irq_id = 0;
    m_pipe.delete();
    for (int k = 0; k < int'(SYNC_STAGES); k++) m_pipe.push_back(8'h00);
  endfunction

  function automatic bit [7:0] m_pending_vec();
    bit [7:0] s, pv;
    s = m_pipe[0];
    for (int i = 0; i < 8; i++) pv[i] = m_pend[i] || (!m_mode[i] && s[i]);
    return pv;
  endfunction

  // Lowest-numbered source that is pending, enabled and not in service; -1 if none
  function automatic int m_first();
    bit [7:0] pv;
    pv = m_pending_vec();
    for (int i = 0; i < 8; i++) begin
      if (pv[i] && m_enable[i] && !m_ins[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [7:0] a);
    int f;
    f = m_first();
    case (a)
      A_CTRL:      return {31'd0, m_en};
      A_ENABLE:    return {24'd0, m_enable};
      A_MODE:      return {24'd0, m_mode};
      A_PENDING:   return {24'd0, m_pending_vec()};
      A_RAW:       return {24'd0, m_pipe[0]};
      A_INSERVICE: return {24'd0, m_ins};
      A_CLAIM:     return (m_en && f >= 0) ? (32'h8000_0000 | 32'(f)) : 32'h0;
      default:     return 32'h0;
    endcase
  endfunction

  // Advance the model by one clock edge using the inputs presented at that edge
  function automatic void m_update();
    int f;
    bit [7:0] s, np, ni;
    bit claim;
    if (!rst_n) begin
      m_clear();
      return;
    end
    s = m_pipe[0];
    f = m_first();
    claim = reg_rd && (reg_addr == A_CLAIM) && m_en && (f >= 0);
    np = m_pend;
    ni = m_ins;
    for (int i = 0; i < 8; i++) begin
      bit set_b, clr_b;
      set_b = (m_mode[i] && s[i] && !m_hist[i]) ||
              (reg_wr && reg_addr == A_SWTRIG && reg_wdata[i]);
      clr_b = (reg_wr && reg_addr == A_PENDING && reg_wdata[i]) || (claim && i == f);
      if (set_b) np[i] = 1'b1;
      else if (clr_b) np[i] = 1'b0;
      if (claim && i == f) ni[i] = 1'b1;
      else if (reg_wr && reg_addr == A_COMPLETE && int'(reg_wdata[2:0]) == i) ni[i] = 1'b0;
    end
    m_irq_out = m_en && (f >= 0);
    m_irq_id  = (f >= 0) ? 3'(f) : 3'd0;
    if (reg_wr && reg_addr == A_CTRL)   m_en = reg_wdata[0];
    if (reg_wr && reg_addr == A_ENABLE) m_enable = reg_wdata[7:0];
    if (reg_wr && reg_addr == A_MODE)   m_mode = reg_wdata[7:0];
    m_pend = np;
    m_ins  = ni;
    m_hist = s;
    m_pipe.push_back(irq_src);
    void'(m_pipe.pop_front());
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic tick();
    @(posedge clk);
    m_update();
    #1;
  endtask

  task automatic bus_idle();
    reg_wr = 0; reg_rd = 0; reg_addr = '0; reg_wdata = '0;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    reg_wr = 1; reg_rd = 0; reg_addr = a; reg_wdata = d;
    tick();
    bus_idle();
  endtask

  task automatic do_reset();
    bus_idle();
    irq_src = '0;
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic setup(input logic [7:0] mode, input logic [7:0] en_mask);
    bus_write(A_MODE, {24'd0, mode});
    bus_write(A_ENABLE, {24'd0, en_mask});
    bus_write(A_CTRL, 32'h1);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [7:0] a;
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    checks++;
    if (irq_out !== 1'b0 || irq_id !== 3'd0) begin
      failures++;
      $display("FAIL reset_outputs irq_out=%0b irq_id=%0d required 0/0", irq_out, irq_id);
    end
    for (int k = 0; k <= 10; k++) begin
      a = 8'(k * 4);
      reg_addr = a;
      #1;
      checks++;
      if (reg_rdata !== 32'h0) begin
        failures++;
        $display("FAIL reset_reg addr=%h got=%h required=0", a, reg_rdata);
      end
      tick();
    end
    bus_idle();
  endtask

  task automatic test_edge();
    do_reset();
    setup(8'hFF, 8'hFF);
    irq_src = 8'h01;
    tick();
    irq_src = 8'h00;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (irq_out !== 1'b0) begin
        failures++;
        $display("FAIL edge_early cycle=%0d irq_out=%0b required 0", k, irq_out);
      end
      tick();
    end
    checks++;
    if (irq_out !== 1'b1 || irq_id !== 3'd0) begin
      failures++;
      $display("FAIL edge_latency irq_out=%0b irq_id=%0d required 1/0", irq_out, irq_id);
    end
    reg_rd = 1; reg_addr = A_CLAIM;
    #1;
    checks++;
    if (reg_rdata !== 32'h8000_0000) begin
      failures++;
      $display("FAIL edge_claim got=%h required=80000000", reg_rdata);
    end
    tick();
    bus_idle();
    tick();
    checks++;
    if (irq_out !== 1'b0) begin
      failures++;
      $display("FAIL edge_after_claim irq_out=%0b required 0", irq_out);
    end
    irq_src = 8'h01;
    tick();
    irq_src = 8'h00;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (irq_out !== 1'b0) begin
        failures++;
        $display("FAIL edge_masked cycle=%0d irq_out=%0b required 0", k, irq_out);
      end
    end
    bus_write(A_COMPLETE, 32'd0);
    tick();
    checks++;
    if (irq_out !== 1'b1 || irq_id !== 3'd0) begin
      failures++;
      $display("FAIL edge_after_complete irq_out=%0b irq_id=%0d required 1/0", irq_out, irq_id);
    end
  endtask

  task automatic test_priority();
    do_reset();
    setup(8'hFF, 8'hFF);
    irq_src = 8'h24;
    tick();
    irq_src = 8'h00;
    repeat (4) tick();
    checks++;
    if (irq_out !== 1'b1 || irq_id !== 3'd2) begin
      failures++;
      $display("FAIL prio_out irq_out=%0b irq_id=%0d required 1/2", irq_out, irq_id);
    end
    reg_rd = 1; reg_addr = A_CLAIM;
    #1;
    checks++;
    if (reg_rdata !== 32'h8000_0002) begin
      failures++;
      $display("FAIL prio_claim1 got=%h required=80000002", reg_rdata);
    end
    tick();
    #1;
    checks++;
    if (reg_rdata !== 32'h8000_0005) begin
      failures++;
      $display("FAIL prio_claim2 got=%h required=80000005", reg_rdata);
    end
    tick();
    bus_idle();
    reg_addr = A_INSERVICE;
    #1;
    checks++;
    if (reg_rdata !== 32'h24) begin
      failures++;
      $display("FAIL prio_inservice got=%h required=24", reg_rdata);
    end
    bus_idle();
  endtask

  task automatic test_level();
    bit seen;
    do_reset();
    setup(8'h00, 8'hFF);
    irq_src = 8'h08;
    seen = 0;
    for (int k = 0; k < 8 && !seen; k++) begin
      tick();
      if (irq_out === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || irq_id !== 3'd3) begin
      failures++;
      $display("FAIL level_assert seen=%0b irq_id=%0d required 1/3", seen, irq_id);
    end
    reg_rd = 1; reg_addr = A_CLAIM;
    #1;
    checks++;
    if (reg_rdata !== 32'h8000_0003) begin
      failures++;
      $display("FAIL level_claim got=%h required=80000003", reg_rdata);
    end
    tick();
    bus_idle();
    tick();
    checks++;
    if (irq_out !== 1'b0) begin
      failures++;
      $display("FAIL level_masked irq_out=%0b required 0", irq_out);
    end
    bus_write(A_COMPLETE, 32'd3);
    tick();
    checks++;
    if (irq_out !== 1'b1 || irq_id !== 3'd3) begin
      failures++;
      $display("FAIL level_reassert irq_out=%0b irq_id=%0d required 1/3", irq_out, irq_id);
    end
    reg_rd = 1; reg_addr = A_CLAIM;
    tick();
    bus_idle();
    irq_src = 8'h00;
    repeat (4) tick();
    bus_write(A_COMPLETE, 32'd3);
    repeat (3) tick();
    checks++;
    if (irq_out !== 1'b0) begin
      failures++;
      $display("FAIL level_dropped irq_out=%0b required 0", irq_out);
    end
  endtask

  task automatic test_collision();
    do_reset();
    setup(8'hFF, 8'h00);
    irq_src = 8'h02;
    tick();
    irq_src = 8'h00;
    tick();
    bus_write(A_PENDING, 32'h2);
    reg_addr = A_PENDING;
    #1;
    checks++;
    if (reg_rdata !== 32'h2) begin
      failures++;
      $display("FAIL collision_pending got=%h required=2", reg_rdata);
    end
    bus_write(A_PENDING, 32'h2);
    reg_addr = A_PENDING;
    #1;
    checks++;
    if (reg_rdata !== 32'h0) begin
      failures++;
      $display("FAIL w1c_pending got=%h required=0", reg_rdata);
    end
    bus_idle();
  endtask

  task automatic test_empty();
    do_reset();
    setup(8'hFF, 8'hFF);
    reg_rd = 1; reg_addr = A_CLAIM;
    #1;
    checks++;
    if (reg_rdata !== 32'h0) begin
      failures++;
      $display("FAIL empty_claim got=%h required=0", reg_rdata);
    end
    tick();
    bus_idle();
    bus_write(A_SWTRIG, 32'h10);
    tick();
    reg_rd = 1; reg_addr = A_CLAIM;
    #1;
    checks++;
    if (reg_rdata !== 32'h8000_0004) begin
      failures++;
      $display("FAIL swtrig_claim got=%h required=80000004", reg_rdata);
    end
    tick();
    #1;
    checks++;
    if (reg_rdata !== 32'h0) begin
      failures++;
      $display("FAIL empty_claim2 got=%h required=0", reg_rdata);
    end
    tick();
    bus_idle();
    bus_write(A_COMPLETE, 32'd7);
    reg_addr = A_INSERVICE;
    #1;
    checks++;
    if (reg_rdata !== 32'h10) begin
      failures++;
      $display("FAIL bogus_complete inservice got=%h required=10", reg_rdata);
    end
    bus_idle();
    tick();
    checks++;
    if (irq_out !== 1'b0) begin
      failures++;
      $display("FAIL bogus_complete irq_out=%0b required 0", irq_out);
    end
    bus_write(A_CTRL, 32'h0);
    bus_write(A_SWTRIG, 32'h01);
    tick();
    tick();
    checks++;
    if (irq_out !== 1'b0) begin
      failures++;
      $display("FAIL gated_irq_out irq_out=%0b required 0", irq_out);
    end
    reg_rd = 1; reg_addr = A_CLAIM;
    #1;
    checks++;
    if (reg_rdata !== 32'h0) begin
      failures++;
      $display("FAIL gated_claim got=%h required=0", reg_rdata);
    end
    tick();
    bus_idle();
    reg_addr = A_PENDING;
    #1;
    checks++;
    if (reg_rdata !== 32'h01) begin
      failures++;
      $display("FAIL gated_pending got=%h required=1", reg_rdata);
    end
    bus_idle();
  endtask

  task automatic test_reset_mid();
    logic [7:0] a;
    do_reset();
    setup(8'hFF, 8'hFF);
    bus_write(A_SWTRIG, 32'h06);
    reg_rd = 1; reg_addr = A_CLAIM;
    tick();
    bus_idle();
    tick();
    checks++;
    if (irq_out !== 1'b1 || irq_id !== 3'd2) begin
      failures++;
      $display("FAIL midreset_pre irq_out=%0b irq_id=%0d required 1/2", irq_out, irq_id);
    end
    rst_n = 0;
    tick();
    rst_n = 1;
    checks++;
    if (irq_out !== 1'b0 || irq_id !== 3'd0) begin
      failures++;
      $display("FAIL midreset_out irq_out=%0b irq_id=%0d required 0/0", irq_out, irq_id);
    end
    for (int k = 0; k <= 8; k++) begin
      a = 8'(k * 4);
      reg_addr = a;
      #1;
      checks++;
      if (reg_rdata !== 32'h0) begin
        failures++;
        $display("FAIL midreset_reg addr=%h got=%h required=0", a, reg_rdata);
      end
      tick();
    end
    bus_idle();
  endtask

  task automatic test_random();
    int r;
    logic [31:0] exp_rd;
    do_reset();
    for (int n = 0; n < 800; n++) begin
      bus_idle();
      if ($urandom_range(0, 2) == 0) irq_src = irq_src ^ (8'h01 << $urandom_range(0, 7));
      rst_n = ($urandom_range(0, 249) != 0);
      r = int'($urandom_range(0, 99));
      if (r < 8) begin
        reg_wr = 1; reg_addr = A_CTRL; reg_wdata = {31'd0, ($urandom_range(0, 3) != 0)};
      end else if (r < 16) begin
        reg_wr = 1; reg_addr = A_ENABLE; reg_wdata = $urandom;
      end else if (r < 22) begin
        reg_wr = 1; reg_addr = A_MODE; reg_wdata = $urandom;
      end else if (r < 30) begin
        reg_wr = 1; reg_addr = A_PENDING; reg_wdata = $urandom;
      end else if (r < 38) begin
        reg_wr = 1; reg_addr = A_SWTRIG; reg_wdata = 32'h1 << $urandom_range(0, 7);
      end else if (r < 52) begin
        reg_wr = 1; reg_addr = A_COMPLETE; reg_wdata = 32'($urandom_range(0, 7));
      end else if (r < 72) begin
        reg_rd = 1; reg_addr = A_CLAIM;
      end else if (r < 90) begin
        reg_rd = ($urandom_range(0, 1) == 1); reg_addr = 8'($urandom_range(0, 15) * 4);
      end
      #1;
      exp_rd = m_rdata(reg_addr);
      checks++;
      if (reg_rdata !== exp_rd) begin
        failures++;
        $display("FAIL rand_rdata n=%0d addr=%h got=%h required=%h", n, reg_addr, reg_rdata, exp_rd);
      end
      tick();
      checks++;
      if (irq_out !== m_irq_out || irq_id !== m_irq_id) begin
        failures++;
        $display("FAIL rand_irq n=%0d irq_out=%0b irq_id=%0d required %0b/%0d",
                 n, irq_out, irq_id, m_irq_out, m_irq_id);
      end
    end
    rst_n = 1;
    bus_idle();
  endtask

  // Hard stop in case a scenario never returns
  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    m_clear();
    test_reset();
    test_edge();
    test_priority();
    test_level();
    test_collision();
    test_empty();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
